// File: rtl/i2c_scl_sequencer.sv
// I2C master bit sequencer: drives open-drain SCL/SDA pull-downs through four equal phases per command.
// Latency: done pulses in the first IDLE cycle, 4*Q cycles after accept (plus stretched cycles); Q = max(div_q,1).
// Backpressure: cmd_ready high only in IDLE; cmd_valid while busy is ignored. Optional macro: I2C_CLK_STRETCH_EN.
module i2c_scl_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_q,
  input  logic [1:0]       cmd,
  input  logic             cmd_wbit,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             done,
  output logic             busy,
  output logic             rx_bit,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_drive_low,
  output logic             sda_drive_low
);

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_q;
  logic [1:0]       r_cmd;
  logic             r_wbit;
  logic             r_scl_low;
  logic             r_sda_low;
  logic             r_done;
  logic             r_rx_bit;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_q_in;
  logic             w_accept;
  logic             w_stall;
  logic             w_tick;
  logic             w_done_nxt;
  logic             w_lv_load;
  logic [1:0]       w_lv_phase;
  logic [1:0]       w_lv_cmd;
  logic             w_lv_wbit;
  logic [1:0]       w_lv;

  // Pull-down pattern {scl_low, sda_low} for a command in phase 0..3 (A..D).
  function automatic logic [1:0] f_drive(input logic [1:0] c, input logic wb, input logic [1:0] ph);
    f_drive = 2'b00;
    case (c)
      CMD_START: begin
        case (ph)
          2'd0:    f_drive = 2'b00;
          2'd1:    f_drive = 2'b00;
          2'd2:    f_drive = 2'b01;
          default: f_drive = 2'b11;
        endcase
      end
      CMD_STOP: begin
        case (ph)
          2'd0:    f_drive = 2'b11;
          2'd1:    f_drive = 2'b01;
          2'd2:    f_drive = 2'b01;
          default: f_drive = 2'b00;
        endcase
      end
      CMD_WRITE: f_drive = {(ph == 2'd0) || (ph == 2'd3), ~wb};
      default:   f_drive = {(ph == 2'd0) || (ph == 2'd3), 1'b0};
    endcase
  endfunction

  assign cmd_ready     = (r_state == IDLE);
  assign busy          = ~cmd_ready;
  assign done          = r_done;
  assign rx_bit        = r_rx_bit;
  assign scl_drive_low = r_scl_low;
  assign sda_drive_low = r_sda_low;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_q_in    = (div_q == '0) ? ONE : div_q;
  assign w_lv_cmd  = w_accept ? cmd : r_cmd;
  assign w_lv_wbit = w_accept ? cmd_wbit : r_wbit;
  assign w_lv      = f_drive(w_lv_cmd, w_lv_wbit, w_lv_phase);

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low right after we release it freezes the phase B counter at zero.
  assign w_stall = (r_state == PH_B) && (r_cmd != CMD_START) && (r_cnt == '0) && !scl_in;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_in;
  assign w_stall      = 1'b0;
`endif

  assign w_tick = (r_state != IDLE) && !w_stall && (r_cnt == (r_q - ONE));

  // Next-state, counter and phase-entry decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_lv_load   = 1'b0;
    w_lv_phase  = 2'd0;
    if (r_state != IDLE) begin
      if (w_tick)       w_cnt_nxt = '0;
      else if (!w_stall) w_cnt_nxt = r_cnt + ONE;
    end
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = PH_A;
          w_cnt_nxt   = '0;
          w_lv_load   = 1'b1;
          w_lv_phase  = 2'd0;
        end
      end
      PH_A: if (w_tick) begin w_state_nxt = PH_B; w_lv_load = 1'b1; w_lv_phase = 2'd1; end
      PH_B: if (w_tick) begin w_state_nxt = PH_C; w_lv_load = 1'b1; w_lv_phase = 2'd2; end
      PH_C: if (w_tick) begin w_state_nxt = PH_D; w_lv_load = 1'b1; w_lv_phase = 2'd3; end
      PH_D: if (w_tick) begin w_state_nxt = IDLE; w_done_nxt = 1'b1; end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and quarter counter registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Command capture on accept; divisor is frozen for the whole command.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_q    <= ONE;
      r_cmd  <= CMD_START;
      r_wbit <= 1'b0;
    end else if (w_accept) begin
      r_q    <= w_q_in;
      r_cmd  <= cmd;
      r_wbit <= cmd_wbit;
    end
  end

  // Line drives change on phase entry and hold through IDLE; READ samples SDA at the end of phase B.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
      r_done    <= 1'b0;
      r_rx_bit  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_lv_load) begin
        r_scl_low <= w_lv[1];
        r_sda_low <= w_lv[0];
      end
      if ((r_state == PH_B) && w_tick && (r_cmd == CMD_READ)) r_rx_bit <= sda_in;
    end
  end

endmodule

// File: tb/tb_i2c_scl_sequencer.sv
// Bench for i2c_scl_sequencer: elapsed-time reference model checked every cycle, plus directed literal checks.
// Model timing is derived from cycles elapsed since accept; line levels from the bus-level phase tables.
// Inputs change 1 time unit after the falling edge; outputs are sampled on the falling edge.
module tb_i2c_scl_sequencer;

  localparam int DIV_W = 8;
`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       cmd;
  logic             cmd_wbit;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             done;
  logic             busy;
  logic             rx_bit;
  logic             scl_in;
  logic             sda_in;
  logic             scl_drive_low;
  logic             sda_drive_low;

  always #5 clk_in = ~clk_in;

  i2c_scl_sequencer #(.DIV_W(DIV_W)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .div_q(div_q), .cmd(cmd), .cmd_wbit(cmd_wbit),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .done(done), .busy(busy), .rx_bit(rx_bit),
    .scl_in(scl_in), .sda_in(sda_in), .scl_drive_low(scl_drive_low), .sda_drive_low(sda_drive_low)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus level (1 = released) for {scl, sda} of a command in phase 0..3, straight from the level tables.
  function automatic logic [1:0] bus_level(input int c, input bit wb, input int ph);
    logic [3:0] s;
    logic [3:0] d;
    case (c)
      0:       begin s = 4'b1110; d = 4'b1100; end
      1:       begin s = 4'b0111; d = 4'b0001; end
      2:       begin s = 4'b0110; d = {4{wb}}; end
      default: begin s = 4'b0110; d = 4'b1111; end
    endcase
    return {s[3-ph], d[3-ph]};
  endfunction

  // Reference model state
  bit m_ok = 0;
  bit m_busy, m_done, m_scl_low, m_sda_low, m_rx;
  int m_e, m_q, m_cmd;
  bit m_wb;

  task automatic model_levels(input int ph);
    logic [1:0] lv;
    lv = bus_level(m_cmd, m_wb, ph);
    m_scl_low = ~lv[1];
    m_sda_low = ~lv[0];
  endtask

  // Model advances on each rising edge from the inputs present at that edge.
  always @(posedge clk_in) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_scl_low = 0; m_sda_low = 0; m_rx = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (cmd_valid) begin
        m_busy = 1; m_e = 0;
        m_q = (div_q == 0) ? 1 : int'(div_q);
        m_cmd = int'(cmd); m_wb = cmd_wbit;
        model_levels(0);
      end
    end else begin
      m_done = 0;
      if (!(STRETCH && m_cmd != 0 && m_e == m_q && !scl_in)) begin
        m_e++;
        if (m_e == 4 * m_q) begin
          m_busy = 0; m_done = 1;
        end else if (m_e % m_q == 0) begin
          model_levels(m_e / m_q);
          if (m_e == 2 * m_q && m_cmd == 3) m_rx = sda_in;
        end
      end
    end
    m_ok = 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_in) begin
    if (m_ok) begin
      check("cmd_ready", cmd_ready, !m_busy);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("scl_drive_low", scl_drive_low, m_scl_low);
      check("sda_drive_low", sda_drive_low, m_sda_low);
      check("rx_bit", rx_bit, m_rx);
    end
  end

  task automatic send(input logic [1:0] c, input logic wb, input logic [DIV_W-1:0] d);
    @(negedge clk_in); #1;
    cmd = c; cmd_wbit = wb; div_q = d; cmd_valid = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in); #1;
    cmd_valid = 1'b0;
  endtask

  int done_k;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b1; cmd = 2'b10; cmd_wbit = 1'b0; div_q = 8'd4;
    sda_in = 1'b1; scl_in = 1'b1;

    // Reset held 3 cycles with cmd_valid asserted
    repeat (3) @(negedge clk_in);
    check("rst_scl", scl_drive_low, 1'b0);
    check("rst_sda", sda_drive_low, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    #1 rst_n = 1'b1; cmd_valid = 1'b0;
    @(negedge clk_in);
    check("rst_no_accept", cmd_ready, 1'b1);

    // START, Q=4
    send(2'b00, 1'b0, 8'd4);
    check("start_k0_sda", sda_drive_low, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk_in);
      if (k == 7)  check("start_k7_sda", sda_drive_low, 1'b0);
      if (k == 8)  check("start_k8_sda", sda_drive_low, 1'b1);
      if (k == 11) check("start_k11_scl", scl_drive_low, 1'b0);
      if (k == 12) check("start_k12_scl", scl_drive_low, 1'b1);
      if (k == 15) check("start_k15_done", done, 1'b0);
      if (k == 16) check("start_k16_done", done, 1'b1);
      if (k == 17) check("start_k17_done", done, 1'b0);
    end

    // WRITE 1, Q=2
    send(2'b10, 1'b1, 8'd2);
    check("wr_k0_scl", scl_drive_low, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (k == 2) check("wr_k2_scl", scl_drive_low, 1'b0);
      if (k == 3) check("wr_k3_sda", sda_drive_low, 1'b0);
      if (k == 5) check("wr_k5_scl", scl_drive_low, 1'b0);
      if (k == 6) check("wr_k6_scl", scl_drive_low, 1'b1);
      if (k == 8) check("wr_k8_done", done, 1'b1);
    end

    // Two READs, Q=3, sda_in 0 then 1
    sda_in = 1'b0;
    send(2'b11, 1'b0, 8'd3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      if (k == 3) check("rd0_k3_sda", sda_drive_low, 1'b0);
      if (k == 6) check("rd0_k6_rx", rx_bit, 1'b0);
    end
    sda_in = 1'b1;
    send(2'b11, 1'b0, 8'd3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      if (k == 5) check("rd1_k5_rx", rx_bit, 1'b0);
      if (k == 6) check("rd1_k6_rx", rx_bit, 1'b1);
      if (k == 12) check("rd1_k12_done", done, 1'b1);
    end

    // div_q=0 with cmd_valid held: WRITE 0 then STOP, divisor wiggled mid-command
    @(negedge clk_in); #1;
    cmd = 2'b10; cmd_wbit = 1'b0; div_q = 8'd0; cmd_valid = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_in);
      if (k == 3) check("held_k3_done", done, 1'b0);
      if (k == 4) check("held_k4_done", done, 1'b1);
      if (k == 4) check("held_k4_ready", cmd_ready, 1'b1);
      if (k == 5) check("held_k5_busy", busy, 1'b1);
      if (k == 9) check("held_k9_done", done, 1'b1);
      if (k == 10) check("held_k10_scl", scl_drive_low, 1'b0);
      if (k == 10) check("held_k10_sda", sda_drive_low, 1'b0);
      #1;
      if (k == 1) begin div_q = 8'd7; cmd = 2'b01; end
      if (k == 3) div_q = 8'd0;
      if (k == 5) cmd_valid = 1'b0;
    end

    // Reset during phase C of a WRITE, Q=4
    send(2'b10, 1'b0, 8'd4);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk_in);
      if (k == 9) check("rstmid_k9_busy", busy, 1'b1);
      if (k == 10) begin
        check("rstmid_scl", scl_drive_low, 1'b0);
        check("rstmid_sda", sda_drive_low, 1'b0);
        check("rstmid_ready", cmd_ready, 1'b1);
        check("rstmid_done", done, 1'b0);
      end
      #1;
      if (k == 9) rst_n = 1'b0;
      if (k == 10) rst_n = 1'b1;
    end

    // SCL held low for 10 cycles in phase B of a WRITE, Q=4
    done_k = STRETCH ? 26 : 16;
    send(2'b10, 1'b1, 8'd4);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk_in);
      if (k == done_k - 1) check("stretch_before_done", done, 1'b0);
      if (k == done_k)     check("stretch_done", done, 1'b1);
      if (k == done_k + 1) check("stretch_after_done", done, 1'b0);
      #1;
      if (k == 3)  scl_in = 1'b0;
      if (k == 14) scl_in = 1'b1;
    end

    // Randomized traffic, occasional reset and SCL stretching
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in); #1;
      cmd_valid = ($urandom_range(2) != 0);
      cmd       = 2'($urandom_range(3));
      cmd_wbit  = 1'($urandom_range(1));
      div_q     = 8'($urandom_range(5));
      sda_in    = 1'($urandom_range(1));
      scl_in    = ($urandom_range(3) != 0);
      rst_n     = ($urandom_range(149) != 0);
    end

    @(negedge clk_in); #1;
    cmd_valid = 1'b0; rst_n = 1'b1; scl_in = 1'b1;
    repeat (40) @(negedge clk_in);
    check("final_idle", cmd_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_scl_sequencer.md
Name: i2c_scl_sequencer

Overview:
- Bit-level timing controller for the I2C functional model's master side.
- Accepts one command at a time (START, STOP, WRITE bit, READ bit) over a valid/ready handshake.
- Derives SCL timing from clk_in through a programmable quarter-period counter.
- Sequences the open-drain SCL/SDA pull-down enables through four equal phases per command.
- Sits between the byte-level master FSM and the bus pads.

Parameters:
- DIV_W, 8, width of the quarter-period divisor port and internal counter.

Ports:
- clk_in  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- div_q  in  DIV_W  quarter-period length in clk_in cycles; sampled on command accept; 0 treated as 1.
- cmd  in  2  command code: 00 START, 01 STOP, 10 WRITE, 11 READ.
- cmd_wbit  in  1  data bit for WRITE; ignored otherwise.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- busy  out  1  equals ~cmd_ready.
- rx_bit  out  1  bit sampled by the last READ.
- scl_in  in  1  SCL pad level.
- sda_in  in  1  SDA pad level.
- scl_drive_low  out  1  1 = pull SCL low.
- sda_drive_low  out  1  1 = pull SDA low.

Behaviour:
- Clocking and reset: one clock (clk_in); reset is synchronous and active-low (rst_n).
- Reset values: scl_drive_low=0, sda_drive_low=0, cmd_ready=1, busy=0, done=0, rx_bit=0, state IDLE, counter 0.
- States: IDLE, PH_A, PH_B, PH_C, PH_D.
- Accept and divisor:
  - Accept when cmd_valid & cmd_ready; the accept edge loads cmd, cmd_wbit and Q=max(div_q,1), and enters PH_A.
  - div_q changes mid-command have no effect.
- Quarter counter:
  - Counts 0..Q-1 in each phase; the tick occurs at count==Q-1.
  - Each tick advances PH_A→PH_B→PH_C→PH_D→IDLE and resets the counter to 0.
  - Every phase lasts exactly Q cycles.
- Line levels per phase (A/B/C/D; SCL and SDA given as bus level, 1 = released):
  - START: SCL 1/1/1/0; SDA 1/1/0/0.
  - STOP: SCL 0/1/1/1; SDA 0/0/0/1.
  - WRITE: SCL 0/1/1/0; SDA = cmd_wbit in all phases.
  - READ: SCL 0/1/1/0; SDA released in all phases.
- Output registers: drive levels update on the same edge as the phase entry (accept edge for PH_A). In IDLE the outputs hold the PH_D levels of the last command.
- READ sampling: sda_in is registered into rx_bit on the PH_B tick edge; rx_bit holds until the next READ.
- Latency:
  - done is asserted in the first IDLE cycle, 4*Q cycles after the accept edge.
  - cmd_ready is high in that same cycle, so a held cmd_valid is accepted there.
  - Back-to-back command period is 4*Q+1 cycles.
- Reset mid-command: on the next edge, return to IDLE and release both lines. The in-flight command is dropped with no done pulse and rx_bit cleared.
- cmd_valid while busy is ignored. No queuing.
- Without the optional feature, scl_in is unused.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined:
  - In PH_B of WRITE, READ and STOP (SCL just released after being driven low), the quarter counter holds at 0 while scl_in==0.
  - Counting starts on the first cycle scl_in==1, so done is delayed by exactly the number of stretched cycles.
  - START and all other phases are unaffected.
- Not defined: scl_in is ignored and timing is fixed at 4*Q.

Test Plan:
1. rst_n=0 for 3 cycles with cmd_valid=1 → scl_drive_low=0, sda_drive_low=0, cmd_ready=1, done=0; no accept during reset.
2. div_q=4, START from idle (accept edge t0):
   - sda_drive_low rises at t0+8.
   - scl_drive_low rises at t0+12.
   - done=1 for exactly one cycle at t0+16.
3. div_q=2, WRITE cmd_wbit=1 → sda_drive_low=0 throughout; scl_drive_low=1 at t0, 0 at t0+2..t0+5, 1 at t0+6; done at t0+8.
4. div_q=3, READ twice with sda_in=0 then sda_in=1 → sda_drive_low=0 throughout; rx_bit=0 after the first PH_B tick (t0+6), then 1 after the second.
5. div_q=0, cmd_valid held: WRITE 0 then STOP → Q=1, done pulses 5 cycles apart; final state both lines released; div_q changed mid-command has no effect.
6. Combined reset and stretch case:
   - rst_n=0 during PH_C of a WRITE with div_q=4 → next edge both lines released, cmd_ready=1, no done.
   - With I2C_CLK_STRETCH_EN: scl_in=0 for 10 cycles in PH_B of a WRITE with div_q=4 → done at t0+26.
